// File: rtl/arbiter_pkg.sv
// arbiter_pkg: shared state type and burst address helper for arbiter_bram.
// Build option: ARB_BRAM_BURST_WRAP_EN makes read bursts wrap inside their
// BURST-aligned block (critical word first); otherwise addresses run linearly.
package arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } arb_bram_state_t;

    // RAM word address of burst word cnt, wrapped to the addr_w-bit RAM space.
    function automatic logic [31:0] burst_next(input logic [31:0] base,
                                               input logic [31:0] cnt,
                                               input int unsigned addr_w,
                                               input int unsigned burst);
        logic [31:0] w_amask;
        logic [31:0] w_sum;
        w_amask = (32'd1 << addr_w) - 32'd1;
        w_sum   = base + cnt;
`ifdef ARB_BRAM_BURST_WRAP_EN
        begin
            logic [31:0] w_bmask;
            w_bmask = burst - 32'd1;
            return ((base & ~w_bmask) | (w_sum & w_bmask)) & w_amask;
        end
`else
        if (burst == 0) return w_sum & w_amask;
        return w_sum & w_amask;
`endif
    endfunction

endpackage

// File: rtl/bram_sp.sv
// bram_sp: single-port synchronous RAM, one write or one read per cycle.
// A read of the address being written returns the previous contents.
module bram_sp #(
    parameter int DN    = 16,
    parameter int MEMAN = 12
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [MEMAN-1:0] i_addr,
    input  logic [DN-1:0]    i_wdata,
    output logic [DN-1:0]    o_rdata
);

    logic [DN-1:0] r_mem [0:(1<<MEMAN)-1];
    logic [DN-1:0] r_q;

    // Registered read with old-data read-during-write; no reset so it maps to block RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_q <= r_mem[i_addr];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/arbiter_bram.sv
// arbiter_bram: block-RAM responder on the memory side of the arbiter.
// Single-word writes, BURST-word reads tagged with the requester id.
// Build option: ARB_BRAM_BURST_WRAP_EN (burst address wraps in its aligned block).
module arbiter_bram
    import arbiter_pkg::*;
#(
    parameter int AN    = 24,
    parameter int DN    = 16,
    parameter int IDN   = 2,
    parameter int BURST = 8,
    parameter int MEMAN = 12
) (
    input  logic           clkSYS,
    input  logic           n_reset,
    input  logic [AN-1:0]  addr,
    input  logic [DN-1:0]  data,
    input  logic [IDN-1:0] id,
    input  logic           req,
    input  logic           wr,
    output logic           ack,
    output logic [DN-1:0]  mem,
    output logic [IDN-1:0] mem_id,
    output logic           valid,
    output logic           busy
);

    localparam int CW = $clog2(BURST);

    arb_bram_state_t r_state;
    arb_bram_state_t w_state_nxt;

    logic [CW-1:0]    r_cnt;
    logic [MEMAN-1:0] r_base;
    logic [IDN-1:0]   r_id;

    logic             r_vld_p1;
    logic [IDN-1:0]   r_id_p1;
    logic             r_vld_p2;
    logic [DN-1:0]    r_mem_p2;
    logic [IDN-1:0]   r_id_p2;

    logic             w_ack;
    logic             w_we;
    logic             w_rd_acc;
    logic             w_last;
    logic [31:0]      w_next;
    logic [MEMAN-1:0] w_rd_addr;
    logic [MEMAN-1:0] w_ram_addr;
    logic [DN-1:0]    w_ram_q;
    logic             w_unused;

    assign w_ack    = req & (r_state == ST_IDLE);
    assign w_we     = w_ack & wr;
    assign w_rd_acc = w_ack & ~wr;
    assign w_last   = (r_cnt == CW'(BURST - 1));

    assign w_next     = burst_next(32'(r_base), 32'(r_cnt), MEMAN, BURST);
    assign w_rd_addr  = w_next[MEMAN-1:0];
    // Writes only happen in IDLE, so the single RAM port is never contended.
    assign w_ram_addr = (r_state == ST_READ) ? w_rd_addr : addr[MEMAN-1:0];

    // Upper request address bits alias onto the RAM and are deliberately ignored.
    assign w_unused = ^{addr[AN-1:MEMAN], w_next[31:MEMAN]};

    bram_sp #(
        .DN    (DN),
        .MEMAN (MEMAN)
    ) u_ram (
        .i_clk   (clkSYS),
        .i_we    (w_we),
        .i_addr  (w_ram_addr),
        .i_wdata (data),
        .o_rdata (w_ram_q)
    );

    // State register.
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a read enters READ for exactly BURST issue cycles.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_rd_acc) w_state_nxt = ST_READ;
            ST_READ: if (w_last)   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch the burst base and owner at acceptance; step the word counter while reading.
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            r_cnt  <= '0;
            r_base <= '0;
            r_id   <= '0;
        end else if (w_rd_acc) begin
            r_cnt  <= '0;
            r_base <= addr[MEMAN-1:0];
            r_id   <= id;
        end else if (r_state == ST_READ) begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // p1: RAM output stage tracking; p2: registered outputs.
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            r_vld_p1 <= 1'b0;
            r_id_p1  <= '0;
            r_vld_p2 <= 1'b0;
            r_mem_p2 <= '0;
            r_id_p2  <= '0;
        end else begin
            r_vld_p1 <= (r_state == ST_READ);
            r_id_p1  <= r_id;
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_mem_p2 <= w_ram_q;
                r_id_p2  <= r_id_p1;
            end
        end
    end

    assign ack    = w_ack;
    assign valid  = r_vld_p2;
    assign mem    = r_mem_p2;
    assign mem_id = r_id_p2;
    assign busy   = (r_state == ST_READ) | r_vld_p1 | r_vld_p2;

endmodule

// File: tb/tb_arbiter_bram.sv
// tb_arbiter_bram: randomized and directed bench with a behavioural model of
// RAM contents and burst timing, checked every cycle, plus literal checks.
`timescale 1ns/1ps
module tb_arbiter_bram;

    localparam int AN    = 24;
    localparam int DN    = 16;
    localparam int IDN   = 2;
    localparam int BURST = 8;
    localparam int MEMAN = 12;
    localparam int DEPTH = 1 << MEMAN;

    logic           clkSYS  = 1'b0;
    logic           n_reset = 1'b0;
    logic [AN-1:0]  addr    = '0;
    logic [DN-1:0]  data    = '0;
    logic [IDN-1:0] id      = '0;
    logic           req     = 1'b0;
    logic           wr      = 1'b0;
    logic           ack;
    logic [DN-1:0]  mem;
    logic [IDN-1:0] mem_id;
    logic           valid;
    logic           busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state: RAM image and per-cycle expectations keyed by edge index.
    logic [DN-1:0]  mm [DEPTH];
    bit             exp_v [int];
    logic [DN-1:0]  exp_m [int];
    logic [IDN-1:0] exp_i [int];
    int             rd_until   = -1;
    int             busy_until = -1;

    logic [DN-1:0]  got_m [$];
    logic [IDN-1:0] got_i [$];
    int             got_c [$];
    int             accs  [$];

    arbiter_bram #(
        .AN(AN), .DN(DN), .IDN(IDN), .BURST(BURST), .MEMAN(MEMAN)
    ) dut (
        .clkSYS (clkSYS),
        .n_reset(n_reset),
        .addr   (addr),
        .data   (data),
        .id     (id),
        .req    (req),
        .wr     (wr),
        .ack    (ack),
        .mem    (mem),
        .mem_id (mem_id),
        .valid  (valid),
        .busy   (busy)
    );

    always #5 clkSYS = ~clkSYS;

    always @(posedge clkSYS) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int word_addr(input int base, input int k);
`ifdef ARB_BRAM_BURST_WRAP_EN
        return (base & ~(BURST - 1)) | ((base + k) & (BURST - 1));
`else
        return (base + k) % DEPTH;
`endif
    endfunction

    // Compare DUT against the model in the middle of each cycle, then advance the model.
    always @(negedge clkSYS) begin
        if (!n_reset) begin
            exp_v.delete();
            exp_m.delete();
            exp_i.delete();
            rd_until   = -1;
            busy_until = -1;
            chk("rst_valid", 32'(valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_mem", 32'(mem), 32'd0);
            chk("rst_mem_id", 32'(mem_id), 32'd0);
        end else begin
            bit ev;
            bit eack;
            int a;
            ev   = exp_v.exists(cyc);
            eack = req && (cyc > rd_until);
            chk("valid", 32'(valid), 32'(ev));
            chk("busy", 32'(busy), 32'(cyc <= busy_until));
            chk("ack", 32'(ack), 32'(eack));
            if (ev) begin
                chk("mem", 32'(mem), 32'(exp_m[cyc]));
                chk("mem_id", 32'(mem_id), 32'(exp_i[cyc]));
                exp_v.delete(cyc);
            end
            if (valid) begin
                got_m.push_back(mem);
                got_i.push_back(mem_id);
                got_c.push_back(cyc);
            end
            if (eack) begin
                a = cyc + 1;
                if (wr) begin
                    mm[addr[MEMAN-1:0]] = data;
                end else begin
                    accs.push_back(a);
                    for (int k = 0; k < BURST; k++) begin
                        int p;
                        p = word_addr(int'(addr[MEMAN-1:0]), k);
                        exp_v[a + 2 + k] = 1'b1;
                        exp_m[a + 2 + k] = mm[p];
                        exp_i[a + 2 + k] = id;
                    end
                    rd_until   = a + BURST - 1;
                    busy_until = a + BURST + 1;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clkSYS);
            #1;
        end
    endtask

    // Hold a request until it is accepted; returns the number of cycles it was pending.
    task automatic do_req(input bit w, input logic [AN-1:0] a, input logic [DN-1:0] d,
                          input logic [IDN-1:0] i, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        req = 1'b1; wr = w; addr = a; data = d; id = i;
        for (int n = 0; n < 4 * BURST && !done; n++) begin
            @(negedge clkSYS);
            waits++;
            if (ack) done = 1'b1;
        end
        if (!done) chk("req_timeout", 32'd0, 32'd1);
        @(posedge clkSYS);
        #1;
        req = 1'b0;
        wr  = 1'b0;
    endtask

    task automatic clear_caps();
        got_m.delete();
        got_i.delete();
        got_c.delete();
        accs.delete();
    endtask

    initial begin
        int w;
        logic [DN-1:0] e;

        idle(3);
        n_reset = 1'b1;
        idle(1);

        // Give every RAM word a known value through the write path.
        for (int p = 0; p < DEPTH; p++) begin
            do_req(1'b1, AN'(p), DN'($urandom), '0, w);
        end

        // Write then read one word.
        clear_caps();
        do_req(1'b1, 24'h000010, 16'h1234, 2'd0, w);
        chk("t1_wr_wait", 32'(w), 32'd1);
        do_req(1'b0, 24'h000010, 16'h0000, 2'd2, w);
        chk("t1_rd_wait", 32'(w), 32'd1);
        idle(BURST + 2);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_words", 32'(got_m.size()), 32'(BURST));
        if (got_m.size() >= BURST && accs.size() >= 1) begin
            chk("t1_word0", 32'(got_m[0]), 32'h1234);
            chk("t1_id0", 32'(got_i[0]), 32'd2);
            chk("t1_latency", 32'(got_c[0] - accs[0]), 32'd2);
            chk("t1_contig", 32'(got_c[BURST-1] - got_c[0]), 32'(BURST - 1));
        end

        // Back-to-back writes, then a linear read of them.
        clear_caps();
        for (int i = 0; i < 11; i++) begin
            do_req(1'b1, AN'(32'h20 + i), DN'(32'hA000 + i), '0, w);
            chk("t2_wr_wait", 32'(w), 32'd1);
        end
        do_req(1'b0, 24'h000020, '0, 2'd1, w);
        idle(BURST + 2);
        chk("t2_words", 32'(got_m.size()), 32'(BURST));
        if (got_m.size() >= BURST) begin
            for (int k = 0; k < BURST; k++) begin
                chk("t2_word", 32'(got_m[k]), 32'hA000 + 32'(k));
            end
        end

        // Unaligned read.
        clear_caps();
        do_req(1'b0, 24'h000023, '0, 2'd0, w);
        idle(BURST + 2);
        chk("t3_words", 32'(got_m.size()), 32'(BURST));
        if (got_m.size() >= BURST) begin
            for (int k = 0; k < BURST; k++) begin
`ifdef ARB_BRAM_BURST_WRAP_EN
                e = DN'(32'hA000 + ((3 + k) & 7));
`else
                e = DN'(32'hA003 + k);
`endif
                chk("t3_word", 32'(got_m[k]), 32'(e));
            end
        end

        // Read across the top of the RAM, with and without upper address bits.
        for (int j = 0; j < BURST; j++) begin
            do_req(1'b1, AN'((32'hFFE + j) & 32'hFFF), DN'(32'hB000 + j), '0, w);
        end
        clear_caps();
        do_req(1'b0, 24'h000FFE, '0, 2'd3, w);
        do_req(1'b0, 24'hF00FFE, '0, 2'd1, w);
        idle(BURST + 2);
        chk("t4_words", 32'(got_m.size()), 32'(2 * BURST));
`ifndef ARB_BRAM_BURST_WRAP_EN
        if (got_m.size() >= 2 * BURST) begin
            for (int k = 0; k < BURST; k++) begin
                chk("t4_word_lo", 32'(got_m[k]), 32'hB000 + 32'(k));
                chk("t4_word_hi", 32'(got_m[BURST + k]), 32'hB000 + 32'(k));
            end
        end
`endif

        // Second requester waiting behind a burst.
        clear_caps();
        do_req(1'b0, 24'h000020, '0, 2'd1, w);
        do_req(1'b0, 24'h000100, '0, 2'd3, w);
        chk("t5_wait2", 32'(w), 32'(BURST + 1));
        idle(BURST + 2);
        chk("t5_words", 32'(got_m.size()), 32'(2 * BURST));
        if (accs.size() >= 2) begin
            chk("t5_ack_gap", 32'(accs[1] - accs[0]), 32'(BURST + 1));
        end
        if (got_i.size() >= 2 * BURST) begin
            chk("t5_id_last1", 32'(got_i[BURST - 1]), 32'd1);
            chk("t5_id_first3", 32'(got_i[BURST]), 32'd3);
        end

        // Reset in the middle of a burst.
        do_req(1'b0, 24'h000010, '0, 2'd2, w);
        idle(4);
        chk("t6_valid_pre", 32'(valid), 32'd1);
        n_reset = 1'b0;
        #1;
        chk("t6_valid", 32'(valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_mem_id", 32'(mem_id), 32'd0);
        idle(2);
        n_reset = 1'b1;
        idle(1);
        clear_caps();
        do_req(1'b0, 24'h000010, '0, 2'd1, w);
        chk("t6_ack_first", 32'(w), 32'd1);
        idle(BURST + 2);
        chk("t6_words", 32'(got_m.size()), 32'(BURST));
        if (got_m.size() >= 1) begin
            chk("t6_word0", 32'(got_m[0]), 32'h1234);
            chk("t6_id0", 32'(got_i[0]), 32'd1);
        end

        // Randomized traffic against the model.
        for (int t = 0; t < 400; t++) begin
            logic [AN-1:0] ra;
            idle($urandom_range(0, 2));
            ra = AN'($urandom);
            if ($urandom_range(0, 3) == 0) ra[MEMAN-1:0] = MEMAN'(DEPTH - 1 - $urandom_range(0, 5));
            do_req(1'($urandom_range(0, 1)), ra, DN'($urandom), IDN'($urandom), w);
        end
        idle(BURST + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
